imm_ext_pipe: RTL
=================

// Module: imm_ext_pipe
// PURPOSE
//  Registered, parametrised immediate generator for the decode stage. Accepts an
//  instruction word plus immediate-type select over a valid/ready handshake and
//  returns the XLEN-wide extended immediate one cycle later. Adds CSR-zimm and
//  shamt types, RV64 support, a tag sidechannel and a 2-entry skid buffer, so
//  decode can stall without losing an instruction. Sits between fetch/IR and the
//  ALU operand muxes.
// PARAMETERS
//  XLEN   32  output width; 32 or 64 only (other values: elaboration error)
//  TAG_W  32  width of in_tag/out_tag (typically the PC); passed through unchanged
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst_n      in   1       synchronous, active-low reset
//  flush      in   1       drop all held entries (branch redirect / trap)
//  in_valid   in   1       In/ImmSrc/in_tag are valid this cycle
//  in_ready   out  1       block can accept this cycle
//  In         in   32      full instruction word
//  ImmSrc     in   3       immediate type select (encoding below)
//  in_tag     in   TAG_W   sideband tag, travels with the instruction
//  out_valid  out  1       Imm_Ext/out_tag/out_err are valid
//  out_ready  in   1       consumer accepts this cycle
//  Imm_Ext    out  XLEN    extended immediate
//  out_tag    out  TAG_W   tag of the presented entry
//  out_err    out  1       ImmSrc was 3'b111 (illegal) for this entry
// BEHAVIOUR
//  Encoding (s=sign-extend from In[31] to XLEN, z=zero-extend):
//   000 I  s{In[31:20]}                    001 S  s{In[31:25],In[11:7]}
//   010 B  s{In[31],In[7],In[30:25],In[11:8],0}
//   011 U  s{In[31:12],12'b0} (sign extension matters only for XLEN=64)
//   100 J  s{In[31],In[19:12],In[20],In[30:21],0}
//   101 Z  z{In[19:15]} (CSR zimm)
//   110 SH z{In[25:20]} if XLEN=64, else z{In[24:20]}
//   111 --> Imm_Ext=0, out_err=1; the entry still flows and is never dropped
//  Datapath: extension is combinational on the inputs and captured at the
//   accepting edge. Latency 1 cycle: accepted at edge N -> out_valid at N+1.
//  Storage: output register (OUT) plus one skid register (SKID).
//   in_ready = !skid_valid (a register-derived value, no combinational path
//   from out_ready).
//   Accept = in_valid && in_ready. Pop = out_valid && out_ready.
//   - OUT empty, or popping while SKID empty: an accepted entry loads into OUT.
//   - OUT full, not popping: an accepted entry loads into SKID.
//   - Pop with SKID full: SKID moves to OUT and SKID empties. in_ready was 0,
//     so nothing is accepted in that cycle.
//   - Ordering is strictly FIFO. No entry is duplicated or dropped except by
//     flush or reset.
//  Flush (sync): at the edge, out_valid=0 and skid_valid=0. Any in_valid in the
//   flush cycle is discarded. in_ready=1 in the following cycle.
//  Reset (rst_n=0 at an edge): out_valid=0, skid_valid=0, Imm_Ext=0, out_tag=0,
//   out_err=0. In the first cycle after reset, in_ready=1. Reset has priority
//   over flush, and flush has priority over accept/pop. Reset mid-stall loses
//   both held entries.
//  While out_valid=1 and out_ready=0, Imm_Ext/out_tag/out_err must hold stable.
//  out_valid must not depend combinationally on out_ready.
// TESTING
//  T1 XLEN=32: In=0xFFF00093 (addi x1,x0,-1), ImmSrc=000, out_ready=1
//     -> next cycle out_valid=1, Imm_Ext=0xFFFFFFFF.
//  T2 In=0xFE112E23 (sw x1,-4(x2)), ImmSrc=001 -> Imm_Ext=0xFFFFFFFC.
//     Same In with ImmSrc=111 -> Imm_Ext=0, out_err=1.
//  T3 XLEN=64: In=0x800000B7 (lui x1,0x80000), ImmSrc=011
//     -> Imm_Ext=0xFFFFFFFF80000000.
//     In=0x000F8000, ImmSrc=101 -> 0x1F.
//     In=0x03F00000, ImmSrc=110 -> 0x3F (XLEN=32: 0x1F).
//  T4 Backpressure: tags 1,2,3,4 offered back-to-back, out_ready=0 for 3 cycles
//     -> tags 1,2 accepted, in_ready=0 from the cycle after tag 2 is accepted.
//     When out_ready=1 -> outputs 1,2,3,4 in order, no gaps beyond one bubble.
//  T5 Flush with OUT and SKID full, plus in_valid=1 in the same cycle
//     -> next cycle out_valid=0, in_ready=1, and that input never appears.
//  T6 rst_n=0 for 1 cycle mid-stall -> all outputs 0, in_ready=1 after.
//     A random valid/ready soak with a scoreboard checks order and values.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Registered RISC-V immediate generator for decode, XLEN 32/64,
// with tag sideband and a 2-entry (OUT + SKID) elastic buffer.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      In,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  Imm_Ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  ent_t out_q, out_d;
  ent_t skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;

  logic [31:0] imm32;
  logic [5:0]  shamt;
  ent_t        new_ent;
  logic        accept;
  logic        pop;
  logic        unused_opcode;

  assign unused_opcode = ^In[6:0];

  // Every type is built as a 32-bit value whose bit 31 is the
  // correct extension bit, so one signed widen covers RV64.
  always_comb begin
    shamt = (XLEN == 64) ? In[25:20] : {1'b0, In[24:20]};
    imm32 = '0;
    case (ImmSrc)
      3'b000: imm32 = {{20{In[31]}}, In[31:20]};
      3'b001: imm32 = {{20{In[31]}}, In[31:25], In[11:7]};
      3'b010: imm32 = {{19{In[31]}}, In[31], In[7],
                       In[30:25], In[11:8], 1'b0};
      3'b011: imm32 = {In[31:12], 12'b0};
      3'b100: imm32 = {{11{In[31]}}, In[31], In[19:12],
                       In[20], In[30:21], 1'b0};
      3'b101: imm32 = {27'b0, In[19:15]};
      3'b110: imm32 = {26'b0, shamt};
      default: imm32 = '0;
    endcase
    new_ent.imm = XLEN'($signed(imm32));
    new_ent.tag = in_tag;
    new_ent.err = (ImmSrc == 3'b111);
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      out_d        = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || pop)) begin
      out_d       = new_ent;
      out_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = new_ent;
      skid_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Imm_Ext   = out_q.imm;
  assign out_tag   = out_q.tag;
  assign out_err   = out_q.err;

endmodule
